cnn_quad_job_ctrl: RTL and testbench

Single-clock job/stream controller for one CNN accelerator quad. Loads per-AWE sequence configuration words and accepts a job. Fetches the input map row by row over a request/ack/stream/complete handshake. Emits one per-lane row-sum result per input row. Cascade ports are a registered pass-through to the neighbouring quad.

---
 rtl/cnn_quad_job_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_cnn_quad_job_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_quad_job_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cnn_quad_job_ctrl                                            |
// | Description : Job/stream controller for one CNN accelerator quad. Loads   |
// |               per-AWE sequence words, accepts a job, fetches the input    |
// |               map row by row and returns one per-lane row sum per row.    |
// |               Cascade ports form a one-entry registered slice to the      |
// |               neighbouring quad.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_if, rst_n          : clock (rising edge), synchronous active-low rst |
// |   job_*                  : job start/accept, row fetch handshake, done     |
// |   cascade_in_* / _out_*  : valid/ready pass-through to neighbouring quad   |
// |   config_*               : per-AWE config beats (lowest index wins)        |
// |   result_*               : per-lane row sums, lane n at [16n+15:16n]       |
// |   pixel_*                : one column per beat, lane n at [16n+15:16n]     |
// | Build option                                                               |
// |   QUAD_SAT_ACCUM_EN      : lane accumulators saturate at all-ones instead  |
// |                            of wrapping modulo 2^C_PIXEL_WIDTH              |
// +----------------------------------------------------------------------------+
module cnn_quad_job_ctrl #(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_NUM_AWE        = 4,
  parameter int C_NUM_CE_PER_AWE = 2,
  parameter int C_BRAM_DEPTH     = 512,
  localparam int C_LANES         = C_NUM_AWE * C_NUM_CE_PER_AWE,
  localparam int C_W             = C_LANES * C_PIXEL_WIDTH
) (
  input  logic                 clk_if,
  input  logic                 rst_n,
  input  logic                 job_start,
  output logic                 job_accept,
  input  logic [31:0]          job_parameters,
  output logic                 job_fetch_request,
  input  logic                 job_fetch_ack,
  input  logic                 job_fetch_complete,
  output logic                 job_complete,
  input  logic                 job_complete_ack,
  input  logic [C_W-1:0]       cascade_in_data,
  input  logic                 cascade_in_valid,
  output logic                 cascade_in_ready,
  output logic [C_W-1:0]       cascade_out_data,
  output logic                 cascade_out_valid,
  input  logic                 cascade_out_ready,
  input  logic [C_NUM_AWE-1:0] config_valid,
  output logic [C_NUM_AWE-1:0] config_accept,
  input  logic [C_W-1:0]       config_data,
  output logic                 result_valid,
  input  logic                 result_accept,
  output logic [C_W-1:0]       result_data,
  input  logic                 pixel_valid,
  output logic                 pixel_ready,
  input  logic [C_W-1:0]       pixel_data
);

  localparam int C_CNT_W  = $clog2(C_BRAM_DEPTH + 1);
  localparam int C_ADDR_W = $clog2(C_BRAM_DEPTH);
  localparam int C_AWE_W  = (C_NUM_AWE > 1) ? $clog2(C_NUM_AWE) : 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH_V = C_CNT_W'(C_BRAM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_STREAM = 3'd2,
    S_WAITC  = 3'd3,
    S_RESULT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_alive;       // low only in the cycle(s) of reset
  logic                     r_job_accept;
  logic [9:0]               r_rows_m1;
  logic [9:0]               r_cols_m1;
  logic [9:0]               r_row;
  logic [10:0]              r_col;
  logic                     r_cmpl_seen;   // row-complete seen while still streaming
  logic [C_PIXEL_WIDTH-1:0] r_acc     [C_LANES];
  logic [C_PIXEL_WIDTH-1:0] w_acc_nxt [C_LANES];
  logic [C_W-1:0]           w_acc_flat;
  logic [C_W-1:0]           r_result;
  logic [C_CNT_W-1:0]       r_cfg_cnt [C_NUM_AWE];
  logic [C_NUM_AWE-1:0]     w_cfg_accept;
  logic                     w_cfg_hit;
  logic [C_AWE_W-1:0]       w_cfg_idx;
  logic [C_ADDR_W-1:0]      w_cfg_addr;
  logic [C_W-1:0]           r_mem [C_NUM_AWE][C_BRAM_DEPTH];
  logic [C_NUM_AWE*C_PIXEL_WIDTH-1:0] r_seq_word;
  logic                     r_cout_valid;
  logic [C_W-1:0]           r_cout_data;
  logic                     w_pixel_ready;
  logic                     w_beat;
  logic                     w_last_beat;
  logic                     w_unused;

  // Config arbitration: lowest-index AWE that is both valid and not full wins.
  always_comb begin
    w_cfg_accept = '0;
    w_cfg_hit    = 1'b0;
    w_cfg_idx    = '0;
    if ((r_state == S_IDLE) && r_alive) begin
      for (int i = 0; i < C_NUM_AWE; i++) begin
        if (!w_cfg_hit && config_valid[i] && (r_cfg_cnt[i] < C_DEPTH_V)) begin
          w_cfg_hit       = 1'b1;
          w_cfg_idx       = C_AWE_W'(i);
          w_cfg_accept[i] = 1'b1;
        end
      end
    end
  end

  assign w_cfg_addr    = r_cfg_cnt[w_cfg_idx][C_ADDR_W-1:0];
  assign config_accept = w_cfg_accept;

  // Sequence memories are never reset; words are stored verbatim.
  always_ff @(posedge clk_if) begin
    if (w_cfg_hit) begin
      r_mem[w_cfg_idx][w_cfg_addr] <= config_data;
    end
  end

  // Sequence word of the current row, staged for the AWE sequencers.
  always_ff @(posedge clk_if) begin
    if (r_state == S_REQ) begin
      for (int i = 0; i < C_NUM_AWE; i++) begin
        r_seq_word[i*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] <=
          r_mem[i][r_row[C_ADDR_W-1:0]][C_PIXEL_WIDTH-1:0];
      end
    end
  end

  // Per-lane accumulate path
  for (genvar n = 0; n < C_LANES; n++) begin : g_lane
    logic [C_PIXEL_WIDTH-1:0] w_pix;
    assign w_pix = pixel_data[n*C_PIXEL_WIDTH +: C_PIXEL_WIDTH];
`ifdef QUAD_SAT_ACCUM_EN
    logic [C_PIXEL_WIDTH:0] w_sum_wide;
    assign w_sum_wide   = {1'b0, r_acc[n]} + {1'b0, w_pix};
    assign w_acc_nxt[n] = w_sum_wide[C_PIXEL_WIDTH] ? {C_PIXEL_WIDTH{1'b1}}
                                                    : w_sum_wide[C_PIXEL_WIDTH-1:0];
`else
    assign w_acc_nxt[n] = r_acc[n] + w_pix;
`endif
    assign w_acc_flat[n*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] = r_acc[n];
  end

  assign w_beat      = pixel_valid & w_pixel_ready;
  assign w_last_beat = w_beat && (r_col == {1'b0, r_cols_m1});

  // FSM state register
  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and Moore outputs
  always_comb begin
    w_state_nxt       = r_state;
    job_fetch_request = 1'b0;
    w_pixel_ready     = 1'b0;
    result_valid      = 1'b0;
    job_complete      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (job_start) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        job_fetch_request = 1'b1;
        if (job_fetch_ack) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_pixel_ready = (r_col <= {1'b0, r_cols_m1});
        // An early row-complete ends the row; missing beats count as zero.
        if (w_last_beat || job_fetch_complete) w_state_nxt = S_WAITC;
      end
      S_WAITC: begin
        if (job_fetch_complete || r_cmpl_seen) w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        result_valid = 1'b1;
        if (result_accept) w_state_nxt = (r_row == r_rows_m1) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        job_complete = 1'b1;
        if (job_complete_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pixel_ready = w_pixel_ready;
  assign job_accept  = r_job_accept;
  assign result_data = r_result;

  // Job datapath: counters, accumulators, result register, config counts
  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      r_alive      <= 1'b0;
      r_job_accept <= 1'b0;
      r_rows_m1    <= '0;
      r_cols_m1    <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_cmpl_seen  <= 1'b0;
      r_result     <= '0;
      for (int n = 0; n < C_LANES; n++) r_acc[n] <= '0;
      for (int i = 0; i < C_NUM_AWE; i++) r_cfg_cnt[i] <= '0;
    end else begin
      r_alive      <= 1'b1;
      r_job_accept <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_start) begin
            r_job_accept <= 1'b1;
            r_rows_m1    <= job_parameters[9:0];
            r_cols_m1    <= job_parameters[19:10];
            r_row        <= '0;
          end
        end
        S_REQ: begin
          if (job_fetch_ack) begin
            r_col       <= '0;
            r_cmpl_seen <= 1'b0;
            for (int n = 0; n < C_LANES; n++) r_acc[n] <= '0;
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            r_col <= r_col + 11'd1;
            for (int n = 0; n < C_LANES; n++) r_acc[n] <= w_acc_nxt[n];
          end
          if (job_fetch_complete) r_cmpl_seen <= 1'b1;
        end
        S_WAITC: begin
          if (job_fetch_complete || r_cmpl_seen) r_result <= w_acc_flat;
        end
        S_RESULT: begin
          if (result_accept && (r_row != r_rows_m1)) r_row <= r_row + 10'd1;
        end
        S_DONE: begin
          if (job_complete_ack) begin
            for (int i = 0; i < C_NUM_AWE; i++) r_cfg_cnt[i] <= '0;
          end
        end
        default: ;
      endcase
      if (w_cfg_hit) begin
        r_cfg_cnt[w_cfg_idx] <= r_cfg_cnt[w_cfg_idx] + 1'b1;
      end
    end
  end

  // Cascade register slice: a full slot can still take a new word in the
  // same cycle the downstream side drains it, so streaming has no bubble.
  assign cascade_in_ready  = r_alive & (~r_cout_valid | cascade_out_ready);
  assign cascade_out_valid = r_cout_valid;
  assign cascade_out_data  = r_cout_data;

  always_ff @(posedge clk_if) begin
    if (!rst_n) begin
      r_cout_valid <= 1'b0;
      r_cout_data  <= '0;
    end else if (cascade_in_ready) begin
      r_cout_valid <= cascade_in_valid;
      if (cascade_in_valid) r_cout_data <= cascade_in_data;
    end
  end

  assign w_unused = ^{job_parameters[31:20], r_seq_word};

endmodule
`default_nettype wire

// File: tb/tb_cnn_quad_job_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cnn_quad_job_ctrl                                         |
// | Description : Self-checking bench for cnn_quad_job_ctrl: config fill and  |
// |               arbitration, table-driven jobs, early row complete, reset   |
// |               mid-job and the cascade register slice.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cnn_quad_job_ctrl;

  localparam int L = 8;
  localparam int W = 128;
`ifdef QUAD_SAT_ACCUM_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic         clk_if = 1'b0;
  logic         rst_n;
  logic         job_start, job_accept;
  logic [31:0]  job_parameters;
  logic         job_fetch_request, job_fetch_ack, job_fetch_complete;
  logic         job_complete, job_complete_ack;
  logic [W-1:0] cascade_in_data, cascade_out_data;
  logic         cascade_in_valid, cascade_in_ready, cascade_out_valid, cascade_out_ready;
  logic [3:0]   config_valid, config_accept;
  logic [W-1:0] config_data;
  logic         result_valid, result_accept;
  logic [W-1:0] result_data;
  logic         pixel_valid, pixel_ready;
  logic [W-1:0] pixel_data;

  always #5 clk_if = ~clk_if;

  cnn_quad_job_ctrl dut (
    .clk_if(clk_if), .rst_n(rst_n),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .cascade_in_data(cascade_in_data), .cascade_in_valid(cascade_in_valid),
    .cascade_in_ready(cascade_in_ready),
    .cascade_out_data(cascade_out_data), .cascade_out_valid(cascade_out_valid),
    .cascade_out_ready(cascade_out_ready),
    .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
    .result_valid(result_valid), .result_accept(result_accept), .result_data(result_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data)
  );

  typedef struct {
    logic [9:0]  rows_m1;
    logic [9:0]  cols_m1;
    logic [15:0] val;
    logic        gappy;
    logic [15:0] exp;
  } job_vec_t;

  job_vec_t vecs[5];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_outs();
    return {job_accept, job_fetch_request, job_complete, cascade_in_ready,
            cascade_out_valid, config_accept, result_valid, pixel_ready};
  endfunction

  function automatic logic sel_val(input int sel);
    case (sel)
      0: return job_fetch_request;
      1: return result_valid;
      default: return job_complete;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    int n = 0;
    while (!sel_val(sel) && n < 2000) begin
      @(negedge clk_if);
      n++;
    end
    if (!sel_val(sel)) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got 0 expected 1", name);
    end
  endtask

  task automatic run_job(input job_vec_t v, input string tag);
    int beats, cyc;
    @(negedge clk_if);
    job_parameters = {12'hA5A, v.cols_m1, v.rows_m1};
    job_start = 1'b1;
    @(negedge clk_if);
    check({tag, " job_accept pulse"}, W'(job_accept), W'(1'b1));
    check({tag, " fetch_request"}, W'(job_fetch_request), W'(1'b1));
    job_start = 1'b0;
    @(negedge clk_if);
    check({tag, " job_accept one cycle"}, W'(job_accept), W'(1'b0));
    for (int r = 0; r <= int'(v.rows_m1); r++) begin
      wait_for(0, {tag, " fetch_request"});
      job_fetch_ack = 1'b1;
      @(negedge clk_if);
      job_fetch_ack = 1'b0;
      beats = 0;
      cyc = 0;
      while (beats < int'(v.cols_m1) + 1 && cyc < 5000) begin
        pixel_valid = !(v.gappy && cyc[0]);
        pixel_data  = {L{v.val}};
        #1;
        if (pixel_valid && pixel_ready) beats++;
        @(negedge clk_if);
        cyc++;
      end
      pixel_valid = 1'b0;
      check({tag, " beats accepted"}, W'(beats), W'(int'(v.cols_m1) + 1));
      #1;
      check({tag, " pixel_ready low after row"}, W'(pixel_ready), W'(1'b0));
      check({tag, " no result before complete"}, W'(result_valid), W'(1'b0));
      @(negedge clk_if);
      job_fetch_complete = 1'b1;
      @(negedge clk_if);
      job_fetch_complete = 1'b0;
      check({tag, " result_valid"}, W'(result_valid), W'(1'b1));
      check({tag, " result_data"}, result_data, {L{v.exp}});
      @(negedge clk_if);
      check({tag, " result held"}, {result_valid, result_data[W-2:0]}, {1'b1, {L{v.exp}}[W-2:0]});
      result_accept = 1'b1;
      @(negedge clk_if);
      result_accept = 1'b0;
    end
    check({tag, " job_complete"}, W'(job_complete), W'(1'b1));
    check({tag, " no extra row"}, W'({result_valid, job_fetch_request}), W'(2'b00));
    @(negedge clk_if);
    check({tag, " job_complete held"}, W'(job_complete), W'(1'b1));
    job_complete_ack = 1'b1;
    @(negedge clk_if);
    job_complete_ack = 1'b0;
    check({tag, " job_complete cleared"}, W'(job_complete), W'(1'b0));
  endtask

  initial begin
    int nacc, a0, a2, bad, stalls;
    logic [15:0] k16;
    logic [W-1:0] exp_res, pat, q[$];

    vecs[0] = '{10'd9, 10'd9, 16'd3,      1'b0, 16'd30};
    vecs[1] = '{10'd0, 10'd9, 16'h2000,   1'b1, SAT ? 16'hFFFF : 16'h4000};
    vecs[2] = '{10'd1, 10'd0, 16'hABCD,   1'b0, 16'hABCD};
    vecs[3] = '{10'd0, 10'd3, 16'h4000,   1'b1, SAT ? 16'hFFFF : 16'h0000};
    vecs[4] = '{10'd2, 10'd4, 16'h0101,   1'b1, 16'h0505};

    rst_n = 1'b0; job_start = 0; job_parameters = '0; job_fetch_ack = 0;
    job_fetch_complete = 0; job_complete_ack = 0; cascade_in_data = '0;
    cascade_in_valid = 0; cascade_out_ready = 0; config_valid = '0; config_data = '0;
    result_accept = 0; pixel_valid = 0; pixel_data = '0;
    repeat (2) @(negedge clk_if);
    check("reset ctrl outputs", W'(ctrl_outs()), '0);
    check("reset result_data", result_data, '0);
    check("reset cascade_out_data", cascade_out_data, '0);
    rst_n = 1'b1;
    @(negedge clk_if);

    // Fill AWE0: exactly C_BRAM_DEPTH accepts out of 600 offers
    nacc = 0;
    for (int c = 0; c < 600; c++) begin
      k16 = 16'(nacc);
      config_valid = 4'b0001;
      config_data  = {{7{k16}}, 16'h0C00 + k16};
      #1;
      if (config_accept[0]) nacc++;
      @(negedge clk_if);
    end
    check("cfg AWE0 accept count", W'(nacc), W'(512));
    #1;
    check("cfg AWE0 full accept", W'(config_accept), W'(4'b0000));
    check("cfg mem word0 lane0", W'(dut.r_mem[0][0][15:0]), W'(16'h0C00));
    check("cfg mem word511 lane0", W'(dut.r_mem[0][511][15:0]), W'(16'h0DFF));
    check("cfg mem word511 lane7", W'(dut.r_mem[0][511][127:112]), W'(16'h01FF));
    config_valid = 4'b0101;
    #1;
    check("cfg AWE0 full -> AWE2", W'(config_accept), W'(4'b0100));

    // Priority: AWE0 wins until full, then AWE2
    @(negedge clk_if);
    config_valid = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk_if);
    rst_n = 1'b1;
    @(negedge clk_if);
    a0 = 0; a2 = 0; bad = 0;
    for (int c = 0; c < 520; c++) begin
      config_valid = 4'b0101;
      #1;
      if (config_accept == 4'b0001) a0++;
      else if (config_accept == 4'b0100 && a0 == 512) a2++;
      else bad++;
      @(negedge clk_if);
    end
    config_valid = 4'b0000;
    check("prio AWE0 accepts", W'(a0), W'(512));
    check("prio AWE2 accepts", W'(a2), W'(8));
    check("prio illegal patterns", W'(bad), W'(0));

    // Table-driven jobs
    for (int i = 0; i < 5; i++) run_job(vecs[i], $sformatf("job%0d", i));

    // Completed job clears config counts
    config_valid = 4'b0001;
    #1;
    check("cfg reopened after job ack", W'(config_accept), W'(4'b0001));
    @(negedge clk_if);
    config_valid = 4'b0000;

    // Early row complete with distinct lanes; job_start ignored outside IDLE
    job_parameters = {12'h000, 10'd9, 10'd0};
    job_start = 1'b1;
    @(negedge clk_if);
    job_start = 1'b0;
    wait_for(0, "early fetch_request");
    job_fetch_ack = 1'b1;
    @(negedge clk_if);
    job_fetch_ack = 1'b0;
    for (int n = 0; n < L; n++) begin
      pat[n*16 +: 16]     = 16'h0010 * 16'(n + 1);
      exp_res[n*16 +: 16] = 16'h0040 * 16'(n + 1);
    end
    job_start = 1'b1;
    for (int b = 0; b < 4; b++) begin
      pixel_valid = 1'b1;
      pixel_data  = pat;
      @(negedge clk_if);
      check("job_start ignored in STREAM", W'(job_accept), W'(1'b0));
      job_start = 1'b0;
    end
    pixel_valid = 1'b0;
    job_fetch_complete = 1'b1;
    @(negedge clk_if);
    job_fetch_complete = 1'b0;
    #1;
    check("early complete ready low", W'(pixel_ready), W'(1'b0));
    @(negedge clk_if);
    check("early complete result_valid", W'(result_valid), W'(1'b1));
    check("early complete result_data", result_data, exp_res);
    result_accept = 1'b1;
    @(negedge clk_if);
    result_accept = 1'b0;
    wait_for(2, "early job_complete");
    job_complete_ack = 1'b1;
    @(negedge clk_if);
    job_complete_ack = 1'b0;

    // Reset during STREAM
    job_parameters = {12'h000, 10'd9, 10'd3};
    job_start = 1'b1;
    @(negedge clk_if);
    job_start = 1'b0;
    wait_for(0, "rst fetch_request");
    job_fetch_ack = 1'b1;
    @(negedge clk_if);
    job_fetch_ack = 1'b0;
    cascade_in_valid = 1'b1;
    cascade_in_data  = {4{32'hDEADBEEF}};
    repeat (3) begin
      pixel_valid = 1'b1;
      pixel_data  = {L{16'd1}};
      @(negedge clk_if);
    end
    config_valid = 4'b0001;
    #1;
    check("cfg blocked outside IDLE", W'(config_accept), W'(4'b0000));
    check("mid-job cascade_out_valid", W'(cascade_out_valid), W'(1'b1));
    rst_n = 1'b0;
    @(negedge clk_if);
    check("mid-job reset ctrl outputs", W'(ctrl_outs()), '0);
    check("mid-job reset cascade_out_data", cascade_out_data, '0);
    check("mid-job reset result_data", result_data, '0);
    rst_n = 1'b1;
    pixel_valid = 1'b0;
    config_valid = 4'b0000;
    cascade_in_valid = 1'b0;
    @(negedge clk_if);
    run_job('{10'd0, 10'd1, 16'd5, 1'b0, 16'd10}, "post-reset job");

    // Cascade slice: full throughput, then random backpressure
    stalls = 0;
    for (int c = 0; c < 260; c++) begin
      if (c < 40) begin
        cascade_in_valid  = 1'b1;
        cascade_out_ready = 1'b1;
      end else if (c < 240) begin
        cascade_in_valid  = 1'($urandom_range(0, 1));
        cascade_out_ready = 1'($urandom_range(0, 1));
      end else begin
        cascade_in_valid  = 1'b0;
        cascade_out_ready = 1'b1;
      end
      cascade_in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (c < 40 && !cascade_in_ready) stalls++;
      if (cascade_out_valid && cascade_out_ready) begin
        if (q.size() == 0) check("cascade unexpected word", W'(1'b1), W'(1'b0));
        else check("cascade data", cascade_out_data, q.pop_front());
      end
      if (cascade_in_valid && cascade_in_ready) q.push_back(cascade_in_data);
      @(negedge clk_if);
    end
    check("cascade no bubble at full rate", W'(stalls), W'(0));
    check("cascade drained", W'(q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
